// File: rtl/iibg_pkg.sv
// Shared definitions for the integral-image buffer generator sequencer.
// Holds state encodings, scale depths, address widths, sub-window bounds
// and the window-membership helper used by the write-enable logic.
package iibg_pkg;

  localparam int WIN    = 23;
  localparam int OFS_19 = 2;
  localparam int OFS_17 = 3;
  localparam int DW     = 21;

  localparam int DEPTH_23 = 529;
  localparam int DEPTH_19 = 361;
  localparam int DEPTH_17 = 289;

  localparam int AW_23 = 10;
  localparam int AW_19 = 9;
  localparam int AW_17 = 9;

  // Row/col counters hold 0..WIN-1
  localparam int RCW = 5;
  localparam logic [RCW-1:0] RC_LAST = RCW'(WIN - 1);
  localparam logic [RCW-1:0] LO_19   = RCW'(OFS_19);
  localparam logic [RCW-1:0] HI_19   = RCW'(OFS_19 + 18);
  localparam logic [RCW-1:0] LO_17   = RCW'(OFS_17);
  localparam logic [RCW-1:0] HI_17   = RCW'(OFS_17 + 16);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_LOAD, ST_READ, ST_DONE
  } ctrl_st_e;

  typedef enum logic [1:0] {
    CH_WAIT, CH_SWEEP, CH_FIN
  } chan_st_e;

  // True when (r,c) lies inside the square [lo,hi] x [lo,hi]
  function automatic logic in_win(input logic [RCW-1:0] r, input logic [RCW-1:0] c,
                                  input logic [RCW-1:0] lo, input logic [RCW-1:0] hi);
    return (r >= lo) && (r <= hi) && (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/iibg_rd_chan.sv
// One read-address sweep channel.
// Ports: iClk/iReset clock and sync reset; start_i high while the top is in
// READ; ready_i buffer ready; full_i downstream full (stalls); rdreq_o read
// request; addr_o registered read address; fin_o sweep finished.
// The channel returns from FIN to WAIT once start_i falls, so it is re-armed
// for the next window as soon as the top leaves READ.
module iibg_rd_chan
  import iibg_pkg::*;
#(
  parameter int DEPTH = 529,
  parameter int AW    = 10
) (
  input  logic          iClk,
  input  logic          iReset,
  input  logic          start_i,
  input  logic          ready_i,
  input  logic          full_i,
  output logic          rdreq_o,
  output logic [AW-1:0] addr_o,
  output logic          fin_o
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  chan_st_e      st_q, st_d;
  logic [AW-1:0] addr_q, addr_d;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      st_q   <= CH_WAIT;
      addr_q <= '0;
    end else begin
      st_q   <= st_d;
      addr_q <= addr_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    addr_d = addr_q;
    case (st_q)
      CH_WAIT:  if (start_i && ready_i) st_d = CH_SWEEP;
      CH_SWEEP: begin
        // ready_i is not consulted here: once started, only full_i stalls
        if (!full_i) begin
          if (addr_q == LAST) begin
            addr_d = '0;
            st_d   = CH_FIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      CH_FIN:   if (!start_i) st_d = CH_WAIT;
      default:  st_d = CH_WAIT;
    endcase
  end

  always_comb begin
    rdreq_o = (st_q == CH_SWEEP) && !full_i;
    fin_o   = (st_q == CH_FIN);
    addr_o  = addr_q;
  end

endmodule

// File: rtl/iibg_ctrl.sv
// Sequencer for the three-scale integral-image buffer generator.
// Ports: iClk/iReset; iStart begins a window; iPix_valid/iPix_data/oPix_ready
// input word stream; oData_to_IIBG + oWrreq_* registered writes; oRst_IIBG
// per-scale clear; iReady_*/iFull_* and oRdreq_*/oAddr_read_* per-scale read
// sweeps; oBusy (not IDLE); oDone (one-cycle completion pulse).
module iibg_ctrl
  import iibg_pkg::*;
(
  input  logic             iClk,
  input  logic             iReset,
  input  logic             iStart,
  input  logic             iPix_valid,
  input  logic [DW-1:0]    iPix_data,
  output logic             oPix_ready,
  output logic [DW-1:0]    oData_to_IIBG,
  output logic             oWrreq_23x23,
  output logic             oWrreq_19x19,
  output logic             oWrreq_17x17,
  output logic [2:0]       oRst_IIBG,
  input  logic             iReady_23x23,
  input  logic             iReady_19x19,
  input  logic             iReady_17x17,
  input  logic             iFull_23x23,
  input  logic             iFull_19x19,
  input  logic             iFull_17x17,
  output logic             oRdreq_23x23,
  output logic             oRdreq_19x19,
  output logic             oRdreq_17x17,
  output logic [AW_23-1:0] oAddr_read_23x23,
  output logic [AW_19-1:0] oAddr_read_19x19,
  output logic [AW_17-1:0] oAddr_read_17x17,
  output logic             oBusy,
  output logic             oDone
);

  ctrl_st_e       st_q, st_d;
  logic [RCW-1:0] row_q, col_q;
  logic [DW-1:0]  data_q;
  logic           wr23_q, wr19_q, wr17_q;
  logic           accept, last_px, chan_start;
  logic [2:0]     fin;

  assign accept     = iPix_valid && (st_q == ST_LOAD);
  assign last_px    = accept && (row_q == RC_LAST) && (col_q == RC_LAST);
  assign chan_start = (st_q == ST_READ);

  // State register
  always_ff @(posedge iClk) begin
    if (iReset) st_q <= ST_IDLE;
    else        st_q <= st_d;
  end

  // Next state
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE:  if (iStart) st_d = ST_CLEAR;
      ST_CLEAR: st_d = ST_LOAD;
      ST_LOAD:  if (last_px) st_d = ST_READ;
      ST_READ:  if (&fin) st_d = ST_DONE;
      ST_DONE:  st_d = ST_IDLE;
      default:  st_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    oPix_ready = (st_q == ST_LOAD);
    oRst_IIBG  = (st_q == ST_CLEAR) ? 3'b111 : 3'b000;
    oBusy      = (st_q != ST_IDLE);
    oDone      = (st_q == ST_DONE);
  end

  // Write path: one cycle behind the accept, enables from the accepted position
  always_ff @(posedge iClk) begin
    if (iReset) begin
      row_q  <= '0;
      col_q  <= '0;
      data_q <= '0;
      wr23_q <= 1'b0;
      wr19_q <= 1'b0;
      wr17_q <= 1'b0;
    end else begin
      wr23_q <= accept;
      wr19_q <= accept && in_win(row_q, col_q, LO_19, HI_19);
      wr17_q <= accept && in_win(row_q, col_q, LO_17, HI_17);
      if (accept) data_q <= iPix_data;
      if (st_q == ST_CLEAR) begin
        row_q <= '0;
        col_q <= '0;
      end else if (accept) begin
        if (col_q == RC_LAST) begin
          col_q <= '0;
          row_q <= (row_q == RC_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  assign oData_to_IIBG = data_q;
  assign oWrreq_23x23  = wr23_q;
  assign oWrreq_19x19  = wr19_q;
  assign oWrreq_17x17  = wr17_q;

  iibg_rd_chan #(.DEPTH(DEPTH_23), .AW(AW_23)) u_ch23 (
    .iClk(iClk), .iReset(iReset), .start_i(chan_start),
    .ready_i(iReady_23x23), .full_i(iFull_23x23),
    .rdreq_o(oRdreq_23x23), .addr_o(oAddr_read_23x23), .fin_o(fin[0])
  );

  iibg_rd_chan #(.DEPTH(DEPTH_19), .AW(AW_19)) u_ch19 (
    .iClk(iClk), .iReset(iReset), .start_i(chan_start),
    .ready_i(iReady_19x19), .full_i(iFull_19x19),
    .rdreq_o(oRdreq_19x19), .addr_o(oAddr_read_19x19), .fin_o(fin[1])
  );

  iibg_rd_chan #(.DEPTH(DEPTH_17), .AW(AW_17)) u_ch17 (
    .iClk(iClk), .iReset(iReset), .start_i(chan_start),
    .ready_i(iReady_17x17), .full_i(iFull_17x17),
    .rdreq_o(oRdreq_17x17), .addr_o(oAddr_read_17x17), .fin_o(fin[2])
  );

endmodule

// File: tb/tb_iibg_ctrl.sv
// Directed bench for iibg_ctrl: inputs change on the falling edge, outputs
// are sampled 1ns later, the DUT samples inputs on the following rising edge.
module tb_iibg_ctrl;
  import iibg_pkg::*;

  logic             iClk = 1'b0;
  logic             iReset = 1'b1;
  logic             iStart = 1'b0;
  logic             iPix_valid = 1'b0;
  logic [DW-1:0]    iPix_data = '0;
  logic             oPix_ready;
  logic [DW-1:0]    oData_to_IIBG;
  logic             oWrreq_23x23, oWrreq_19x19, oWrreq_17x17;
  logic [2:0]       oRst_IIBG;
  logic             iReady_23x23 = 1'b0, iReady_19x19 = 1'b0, iReady_17x17 = 1'b0;
  logic             iFull_23x23 = 1'b0, iFull_19x19 = 1'b0, iFull_17x17 = 1'b0;
  logic             oRdreq_23x23, oRdreq_19x19, oRdreq_17x17;
  logic [AW_23-1:0] oAddr_read_23x23;
  logic [AW_19-1:0] oAddr_read_19x19;
  logic [AW_17-1:0] oAddr_read_17x17;
  logic             oBusy, oDone;

  int vectors = 0;
  int miscompares = 0;

  always #5 iClk = ~iClk;

  iibg_ctrl dut (
    .iClk(iClk), .iReset(iReset), .iStart(iStart),
    .iPix_valid(iPix_valid), .iPix_data(iPix_data), .oPix_ready(oPix_ready),
    .oData_to_IIBG(oData_to_IIBG),
    .oWrreq_23x23(oWrreq_23x23), .oWrreq_19x19(oWrreq_19x19), .oWrreq_17x17(oWrreq_17x17),
    .oRst_IIBG(oRst_IIBG),
    .iReady_23x23(iReady_23x23), .iReady_19x19(iReady_19x19), .iReady_17x17(iReady_17x17),
    .iFull_23x23(iFull_23x23), .iFull_19x19(iFull_19x19), .iFull_17x17(iFull_17x17),
    .oRdreq_23x23(oRdreq_23x23), .oRdreq_19x19(oRdreq_19x19), .oRdreq_17x17(oRdreq_17x17),
    .oAddr_read_23x23(oAddr_read_23x23), .oAddr_read_19x19(oAddr_read_19x19),
    .oAddr_read_17x17(oAddr_read_17x17),
    .oBusy(oBusy), .oDone(oDone)
  );

  // All outputs concatenated; zero means every output is at its reset value
  function automatic logic [71:0] all_outs();
    return {oPix_ready, oData_to_IIBG, oWrreq_23x23, oWrreq_19x19, oWrreq_17x17,
            oRst_IIBG, oRdreq_23x23, oRdreq_19x19, oRdreq_17x17,
            oAddr_read_23x23, oAddr_read_19x19, oAddr_read_17x17, oBusy, oDone};
  endfunction

  task automatic test_reset();
    iReset = 1'b1;
    repeat (3) @(negedge iClk);
    #1;
    vectors++;
    if (all_outs() !== 72'd0) begin
      miscompares++;
      $display("FAIL reset_outs got %h want 0", all_outs());
    end
    @(negedge iClk);
    iReset = 1'b0;
    @(negedge iClk);
    #1;
    vectors++;
    if ({oBusy, oPix_ready, oRst_IIBG} !== 5'd0) begin
      miscompares++;
      $display("FAIL idle_after_reset got %b want 00000", {oBusy, oPix_ready, oRst_IIBG});
    end
    @(negedge iClk);
  endtask

  // Load one window; data word = index. gap=1 toggles valid every cycle.
  task automatic test_load(input bit gap);
    int nacc = 0, n23 = 0, n19 = 0, n17 = 0, nrst = 0, rbad = 0, cyc = 0;
    int f19 = -1, f17 = -1, derr = 0, werr = 0, r, c;
    bit tog = 1'b1, e19, e17;
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    while (n23 < 529 && cyc < 3000) begin
      iPix_valid = gap ? tog : 1'b1;
      tog = ~tog;
      iPix_data = DW'(nacc);
      #1;
      if (oRst_IIBG != 3'd0) begin
        nrst++;
        if (oRst_IIBG !== 3'b111) rbad++;
      end
      if (oWrreq_23x23) begin
        r = n23 / 23;
        c = n23 % 23;
        e19 = (r >= 2 && r <= 20 && c >= 2 && c <= 20);
        e17 = (r >= 3 && r <= 19 && c >= 3 && c <= 19);
        if (oData_to_IIBG !== DW'(n23)) derr++;
        if (oWrreq_19x19 !== e19 || oWrreq_17x17 !== e17) werr++;
        if (oWrreq_19x19) begin
          if (f19 < 0) f19 = int'(oData_to_IIBG);
          n19++;
        end
        if (oWrreq_17x17) begin
          if (f17 < 0) f17 = int'(oData_to_IIBG);
          n17++;
        end
        n23++;
      end else if (oWrreq_19x19 || oWrreq_17x17) begin
        werr++;
      end
      if (iPix_valid && oPix_ready) nacc++;
      cyc++;
      @(negedge iClk);
    end
    iPix_valid = 1'b0;
    vectors++;
    if (n23 != 529) begin miscompares++; $display("FAIL wr23_count got %0d want 529", n23); end
    vectors++;
    if (n19 != 361) begin miscompares++; $display("FAIL wr19_count got %0d want 361", n19); end
    vectors++;
    if (n17 != 289) begin miscompares++; $display("FAIL wr17_count got %0d want 289", n17); end
    vectors++;
    if (nrst != 1 || rbad != 0) begin
      miscompares++;
      $display("FAIL clear_pulse cycles %0d bad %0d want 1 and 0", nrst, rbad);
    end
    vectors++;
    if (f19 != 48) begin miscompares++; $display("FAIL first_wr19 got %0d want 48", f19); end
    vectors++;
    if (f17 != 72) begin miscompares++; $display("FAIL first_wr17 got %0d want 72", f17); end
    vectors++;
    if (derr != 0) begin miscompares++; $display("FAIL load_data errors %0d want 0", derr); end
    vectors++;
    if (werr != 0) begin miscompares++; $display("FAIL wr_window errors %0d want 0", werr); end
    vectors++;
    if (gap && cyc < 1000) begin
      miscompares++;
      $display("FAIL gap_stretch cycles %0d want >= 1000", cyc);
    end
    vectors++;
    if (oPix_ready !== 1'b0 || oBusy !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_load got ready %b busy %b want 0 1", oPix_ready, oBusy);
    end
  endtask

  // Staggered readies, 5-cycle full stall on 19x19 at address 100, stray iStart.
  task automatic test_read();
    int c = 0, n23 = 0, n19 = 0, n17 = 0, f23 = -1, f19 = -1, f17 = -1;
    int hold = 0, aerr = 0, nrst = 0, ndone = 0, donecyc = -1, last23 = -1;
    while (c < 1500 && !(donecyc >= 0 && c > donecyc + 2)) begin
      iReady_17x17 = (c < 20);
      iReady_19x19 = (c >= 10);
      iReady_23x23 = (c >= 50);
      iStart       = (c == 30);
      iFull_19x19  = (n19 == 100 && hold < 5);
      #1;
      if (iFull_19x19) begin
        vectors++;
        if (oRdreq_19x19 !== 1'b0 || oAddr_read_19x19 !== 9'd100) begin
          miscompares++;
          $display("FAIL full_stall rdreq %b addr %0d want 0 100", oRdreq_19x19, oAddr_read_19x19);
        end
        hold++;
      end
      if (oRdreq_23x23) begin
        if (f23 < 0) f23 = c;
        if (oAddr_read_23x23 !== AW_23'(n23)) aerr++;
        n23++;
        last23 = c;
      end
      if (oRdreq_19x19) begin
        if (f19 < 0) f19 = c;
        if (oAddr_read_19x19 !== AW_19'(n19)) aerr++;
        n19++;
      end
      if (oRdreq_17x17) begin
        if (f17 < 0) f17 = c;
        if (oAddr_read_17x17 !== AW_17'(n17)) aerr++;
        n17++;
      end
      if (oRst_IIBG != 3'd0) nrst++;
      if (oDone) begin ndone++; donecyc = c; end
      c++;
      @(negedge iClk);
    end
    iReady_17x17 = 1'b0; iReady_19x19 = 1'b0; iReady_23x23 = 1'b0;
    iStart = 1'b0; iFull_19x19 = 1'b0;
    vectors++;
    if (f17 != 1 || f19 != 11 || f23 != 51) begin
      miscompares++;
      $display("FAIL sweep_start got %0d %0d %0d want 1 11 51", f17, f19, f23);
    end
    vectors++;
    if (n17 != 289 || n19 != 361 || n23 != 529) begin
      miscompares++;
      $display("FAIL rdreq_counts got %0d %0d %0d want 289 361 529", n17, n19, n23);
    end
    vectors++;
    if (aerr != 0) begin miscompares++; $display("FAIL read_addr errors %0d want 0", aerr); end
    vectors++;
    if (hold != 5) begin miscompares++; $display("FAIL full_hold cycles %0d want 5", hold); end
    vectors++;
    if (nrst != 0) begin miscompares++; $display("FAIL start_ignored clears %0d want 0", nrst); end
    vectors++;
    if (ndone != 1 || donecyc != last23 + 2) begin
      miscompares++;
      $display("FAIL done_pulse count %0d at %0d want 1 at %0d", ndone, donecyc, last23 + 2);
    end
    vectors++;
    if (oBusy !== 1'b0) begin miscompares++; $display("FAIL idle_after_done busy %b want 0", oBusy); end
  endtask

  task automatic test_reset_midload();
    int nacc = 0, cyc = 0;
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    iPix_valid = 1'b1;
    while (nacc < 200 && cyc < 1000) begin
      iPix_data = DW'(nacc);
      #1;
      if (oPix_ready) nacc++;
      cyc++;
      @(negedge iClk);
    end
    iReset = 1'b1;
    iPix_valid = 1'b0;
    @(negedge iClk);
    #1;
    vectors++;
    if (all_outs() !== 72'd0) begin
      miscompares++;
      $display("FAIL midload_reset got %h want 0", all_outs());
    end
    iReset = 1'b0;
    @(negedge iClk);
  endtask

  initial begin
    test_reset();
    test_load(1'b0);
    test_read();
    test_load(1'b1);
    test_read();
    test_reset_midload();
    test_load(1'b0);
    test_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
